// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: the decode-facing payload, the FSM states and the reset PC.
// Pure declarations; no latency or backpressure of its own.
package fetch_pkg;
  localparam int          DATA_W       = 32;
  localparam int          ADDR_W       = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc4;
  } fetch_out_t;
endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry skid register for fetch_out_t; zero-latency pass of the held entry, flush wins.
// in_rdy_o stays high while empty or while the held entry is being taken downstream.
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_i,
  input  logic       in_vld_i,
  input  fetch_out_t in_dat_i,
  output logic       in_rdy_o,
  output logic       out_vld_o,
  output fetch_out_t out_dat_o,
  input  logic       out_rdy_i
);
  logic       full_q, full_d;
  fetch_out_t dat_q, dat_d;
  logic       push, pop;

  assign in_rdy_o  = !full_q || out_rdy_i;
  assign out_vld_o = full_q;
  assign out_dat_o = dat_q;

  always_comb begin
    full_d = full_q;
    dat_d  = dat_q;
    push   = in_vld_i && in_rdy_o;
    pop    = full_q && out_rdy_i;
    if (flush_i) begin
      full_d = 1'b0;
    end else if (push) begin
      full_d = 1'b1;
      dat_d  = in_dat_i;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      dat_q  <= '0;
    end else begin
      full_q <= full_d;
      dat_q  <= dat_d;
    end
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, inflight tracking for a 1-cycle ROM, output slot plus skid toward decode.
// Issue-to-valid latency 2 cycles; decode stall parks one word in the skid and freezes issue.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = DATA_W,
  parameter int                    ADDR_WIDTH = ADDR_W,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = RESET_PC_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_instr_i,
  output logic                  if_valid_o,
  input  logic                  if_ready_i,
  output logic [DATA_WIDTH-1:0] if_instr_o,
  output logic [ADDR_WIDTH-1:0] if_pc_o,
  output logic [ADDR_WIDTH-1:0] if_pc4_o,
  output logic                  misaligned_o
);
  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d;
  logic                  inflight_q, inflight_d;
  logic                  out_vld_q, out_vld_d;
  fetch_out_t            out_q, out_d;
  logic                  misaligned_q, misaligned_d;

  logic       slot_free, issue;
  logic       skid_in_vld, skid_in_rdy, skid_out_vld, skid_push, skid_pop, skid_full_next;
  fetch_out_t new_word, skid_out_dat;

  fetch_skid_buffer u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (redirect_i),
    .in_vld_i  (skid_in_vld),
    .in_dat_i  (new_word),
    .in_rdy_o  (skid_in_rdy),
    .out_vld_o (skid_out_vld),
    .out_dat_o (skid_out_dat),
    .out_rdy_i (slot_free)
  );

  always_comb begin
    slot_free   = !out_vld_q || if_ready_i;
    new_word    = '{instr: mem_instr_i, pc: inflight_pc_q, pc4: inflight_pc_q + PC_STEP};
    skid_in_vld = inflight_q && !redirect_i && (skid_out_vld || !slot_free);
    skid_push   = skid_in_vld && skid_in_rdy;
    skid_pop    = skid_out_vld && slot_free;
    skid_full_next = skid_push || (skid_out_vld && !skid_pop);
    // Also hold issue while the returning word is about to park in the skid, so the
    // word issued now always has a place to land next cycle.
    issue = (state_q == RUN) && fetch_en_i && !redirect_i && !skid_out_vld
            && !(inflight_q && !slot_free);
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    out_vld_d     = out_vld_q;
    out_d         = out_q;
    misaligned_d  = 1'b0;
    if (issue) begin
      pc_d          = pc_q + PC_STEP;
      inflight_pc_d = pc_q;
    end
    if (redirect_i) begin
      pc_d         = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
      misaligned_d = |redirect_pc_i[1:0];
      out_vld_d    = 1'b0;
      state_d      = RUN;
    end else begin
      if (slot_free) begin
        if (skid_out_vld) begin
          out_vld_d = 1'b1;
          out_d     = skid_out_dat;
        end else if (inflight_q) begin
          out_vld_d = 1'b1;
          out_d     = new_word;
        end else begin
          out_vld_d = 1'b0;
        end
      end
      case (state_q)
        BOOT:    state_d = RUN;
        RUN:     if (skid_full_next) state_d = HOLD;
        HOLD:    if (!skid_full_next) state_d = RUN;
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      out_vld_q     <= 1'b0;
      out_q         <= '0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      out_vld_q     <= out_vld_d;
      out_q         <= out_d;
      misaligned_q  <= misaligned_d;
    end
  end

  assign mem_addr_o   = pc_q;
  assign if_valid_o   = out_vld_q;
  assign if_instr_o   = out_q.instr;
  assign if_pc_o      = out_q.pc;
  assign if_pc4_o     = out_q.pc4;
  assign misaligned_o = misaligned_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit against a synchronous ROM whose word is a fixed
// XOR of its byte address; outputs are sampled on the falling edge.
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_instr_i;
  logic        if_valid_o;
  logic        if_ready_i;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_pc4_o;
  logic        misaligned_o;

  int total = 0;
  int bad   = 0;

  instruction_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en_i    (fetch_en_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .mem_addr_o    (mem_addr_o),
    .mem_instr_i   (mem_instr_i),
    .if_valid_o    (if_valid_o),
    .if_ready_i    (if_ready_i),
    .if_instr_o    (if_instr_o),
    .if_pc_o       (if_pc_o),
    .if_pc4_o      (if_pc4_o),
    .misaligned_o  (misaligned_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  always @(posedge clk) mem_instr_i <= rom_word(mem_addr_o);

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the next valid output, check it, and let decode take it.
  task automatic get_next(input string tag, input logic [31:0] exp_pc);
    logic [31:0] exp_pc4;
    int n;
    exp_pc4 = exp_pc + 32'd4;
    n = 0;
    while (!if_valid_o && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_vld"}, {31'd0, if_valid_o}, 32'd1);
    if (if_valid_o) begin
      chk({tag, "_pc"}, if_pc_o, exp_pc);
      chk({tag, "_pc4"}, if_pc4_o, exp_pc4);
      chk({tag, "_instr"}, if_instr_o, rom_word(exp_pc));
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_en_i = 1'b1;
    if_ready_i = 1'b1;
    redirect_i = 1'b0;
    redirect_pc_i = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_vld", {31'd0, if_valid_o}, 32'd0);
    chk("rst_instr", if_instr_o, 32'd0);
    chk("rst_pc", if_pc_o, 32'd0);
    chk("rst_pc4", if_pc4_o, 32'd0);
    chk("rst_mis", {31'd0, misaligned_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'h0040_0000);

    // 1: boot cycle, then one issue per cycle, first valid two cycles after first issue
    rst_n = 1'b1;
    chk("boot_vld", {31'd0, if_valid_o}, 32'd0);
    tick();
    chk("t1_addr0", mem_addr_o, 32'h0040_0000);
    chk("t1_vld0", {31'd0, if_valid_o}, 32'd0);
    tick();
    chk("t1_addr1", mem_addr_o, 32'h0040_0004);
    chk("t1_vld1", {31'd0, if_valid_o}, 32'd0);
    tick();
    chk("t1_addr2", mem_addr_o, 32'h0040_0008);
    chk("t1_vld2", {31'd0, if_valid_o}, 32'd1);
    chk("t1_pc2", if_pc_o, 32'h0040_0000);
    chk("t1_pc4_2", if_pc4_o, 32'h0040_0004);
    chk("t1_instr2", if_instr_o, rom_word(32'h0040_0000));
    tick();
    chk("t1_addr3", mem_addr_o, 32'h0040_000C);
    chk("t1_pc3", if_pc_o, 32'h0040_0004);

    // 2: decode stalls for three cycles; output holds, nothing lost or repeated
    if_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold_vld", {31'd0, if_valid_o}, 32'd1);
      chk("t2_hold_pc", if_pc_o, 32'h0040_0004);
    end
    if_ready_i = 1'b1;
    get_next("t2_a", 32'h0040_0004);
    get_next("t2_b", 32'h0040_0008);
    get_next("t2_c", 32'h0040_000C);
    get_next("t2_d", 32'h0040_0010);

    // 3: redirect with a fetch in flight
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0040_0040;
    tick();
    redirect_i = 1'b0;
    chk("t3_vld0", {31'd0, if_valid_o}, 32'd0);
    chk("t3_addr0", mem_addr_o, 32'h0040_0040);
    chk("t3_mis", {31'd0, misaligned_o}, 32'd0);
    tick();
    chk("t3_vld1", {31'd0, if_valid_o}, 32'd0);
    chk("t3_addr1", mem_addr_o, 32'h0040_0044);
    tick();
    chk("t3_vld2", {31'd0, if_valid_o}, 32'd1);
    chk("t3_pc2", if_pc_o, 32'h0040_0040);
    get_next("t3_a", 32'h0040_0040);
    get_next("t3_b", 32'h0040_0044);

    // 4: misaligned target is aligned down and flagged for exactly one cycle
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0040_0043;
    tick();
    redirect_i = 1'b0;
    chk("t4_mis_hi", {31'd0, misaligned_o}, 32'd1);
    chk("t4_addr", mem_addr_o, 32'h0040_0040);
    tick();
    chk("t4_mis_lo", {31'd0, misaligned_o}, 32'd0);
    get_next("t4_a", 32'h0040_0040);
    get_next("t4_b", 32'h0040_0044);

    // redirect still applies with fetch disabled, and no issue follows until re-enabled
    fetch_en_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0040_0100;
    tick();
    redirect_i = 1'b0;
    tick();
    tick();
    chk("en0_addr", mem_addr_o, 32'h0040_0100);
    chk("en0_vld", {31'd0, if_valid_o}, 32'd0);
    fetch_en_i = 1'b1;
    get_next("en1_a", 32'h0040_0100);

    // 5: PC wraps past the top of the address space
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    get_next("t5_a", 32'hFFFF_FFFC);
    get_next("t5_b", 32'h0000_0000);

    // 6: asynchronous reset during a stall with the skid occupied
    if_ready_i = 1'b0;
    tick();
    tick();
    chk("t6_pre_vld", {31'd0, if_valid_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_vld", {31'd0, if_valid_o}, 32'd0);
    chk("t6_instr", if_instr_o, 32'd0);
    chk("t6_pc", if_pc_o, 32'd0);
    chk("t6_pc4", if_pc4_o, 32'd0);
    chk("t6_addr", mem_addr_o, 32'h0040_0000);
    if_ready_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    get_next("t6_a", 32'h0040_0000);
    get_next("t6_b", 32'h0040_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
